// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: frame constants, receiver states
// and the bit-counter sizing helper used by both link ends.
package serial_link_pkg;

    localparam int   SERIAL_WORD_WIDTH = 40;
    localparam logic SERIAL_START_BIT  = 1'b1;
    localparam logic SERIAL_IDLE_BIT   = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        STOP   = 2'd2,
        RESYNC = 2'd3
    } serial_state_e;

    // Counter must reach WIDTH, hence the +1.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_frame_receiver.sv
// Serial link deserialiser: start bit, WIDTH data bits MSB first, idle stop bit.
// Optional saturating error counter enabled by SERIAL_RX_ERR_COUNT_EN.
//
//   state  | meaning
//   IDLE   | waiting for start bit ('1')
//   SHIFT  | shifting in data bits
//   STOP   | sampling trailing idle bit
//   RESYNC | after framing error, waiting for line to return low
module serial_frame_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH = SERIAL_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun
`ifdef SERIAL_RX_ERR_COUNT_EN
    ,
    input  logic             err_clr,
    output logic [7:0]       err_count
`endif
);

    localparam int CW = bit_cnt_width(WIDTH);

    serial_state_e    r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_ovr;

    logic w_last_bit;
    logic w_stop_good;
    logic w_can_load;

    assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));
    assign w_stop_good = (r_state == STOP) && (sin == SERIAL_IDLE_BIT);
    assign w_can_load  = !r_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (sin == SERIAL_START_BIT) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_shreg <= {r_shreg[WIDTH-2:0], sin};
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last_bit) r_state <= STOP;
                end
                STOP: begin
                    if (sin == SERIAL_IDLE_BIT) begin
                        r_state <= IDLE;
                    end else begin
                        r_ferr  <= 1'b1;
                        r_state <= RESYNC;
                    end
                end
                RESYNC: begin
                    if (sin == SERIAL_IDLE_BIT) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // A word arriving while the previous one is still unclaimed is dropped.
            if (w_stop_good) begin
                if (w_can_load) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

`ifdef SERIAL_RX_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    // Counts the registered error pulses; clear takes priority over an event.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_err_cnt <= 8'd0;
        end else if ((r_ferr || r_ovr) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: directed frames plus randomized
// traffic against a frame-level model of the holding stage and error pulses.
module tb_serial_frame_receiver;

    localparam int W = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;
    logic         overrun;
`ifdef SERIAL_RX_ERR_COUNT_EN
    logic         err_clr;
    logic [7:0]   err_count;
`endif

    always #5 clk = ~clk;

    serial_frame_receiver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef SERIAL_RX_ERR_COUNT_EN
        ,
        .err_clr   (err_clr),
        .err_count (err_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: what the outputs must be after the most recent edge.
    logic [W-1:0] m_data  = '0;
    bit           m_valid = 1'b0;
    bit           m_ferr  = 1'b0;
    bit           m_ovr   = 1'b0;
    int           m_cnt   = 0;

    int  cyc     = 0;
    int  ready_mode = 1;
    bit  started = 1'b0;

    int           acc_cyc[$];
    logic [W-1:0] acc_data[$];
    int           n_ferr = 0;
    int           n_ovr  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ev: 0 nothing, 1 good stop bit carrying word d, 2 bad stop bit.
    task automatic model_step(input bit r, input bit rdy, input int ev,
                              input logic [W-1:0] d, input bit clr);
        bit prev_evt;
        prev_evt = m_ferr || m_ovr;
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            m_ferr = (ev == 2);
            m_ovr  = 1'b0;
            if (ev == 1) begin
                if (!m_valid || rdy) begin
                    m_data  = d;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        if (r || clr) m_cnt = 0;
        else if (prev_evt && m_cnt < 255) m_cnt++;
    endtask

    task automatic tick(input bit s, input bit r, input int ev,
                        input logic [W-1:0] d, input bit clr);
        bit rdy;
        case (ready_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        sin       = s;
        rst       = r;
        out_ready = rdy;
`ifdef SERIAL_RX_ERR_COUNT_EN
        err_clr   = clr;
`endif
        @(posedge clk);
        cyc++;
        model_step(r, rdy, ev, d, clr);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    // rst_at >= 0 replaces that data bit with a reset cycle and abandons the frame.
    task automatic send_frame(input logic [W-1:0] d, input int stop_ones, input int rst_at,
                              input bit clr_after, output int start_cyc);
        tick(1'b1, 1'b0, 0, '0, 1'b0);
        start_cyc = cyc;
        for (int i = 0; i < W; i++) begin
            if (i == rst_at) begin
                tick(1'($urandom_range(0, 1)), 1'b1, 0, '0, 1'b0);
                return;
            end
            tick(d[W-1-i], 1'b0, 0, '0, 1'b0);
        end
        if (stop_ones == 0) begin
            tick(1'b0, 1'b0, 1, d, 1'b0);
        end else begin
            tick(1'b1, 1'b0, 2, '0, 1'b0);
            for (int k = 1; k < stop_ones; k++) tick(1'b1, 1'b0, 0, '0, 1'b0);
            tick(1'b0, 1'b0, 0, '0, clr_after);
        end
    endtask

    task automatic clear_mon();
        acc_cyc.delete();
        acc_data.delete();
        n_ferr = 0;
        n_ovr  = 0;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("out_data",  64'(out_data),  64'(m_data));
            chk("frame_err", 64'(frame_err), 64'(m_ferr));
            chk("overrun",   64'(overrun),   64'(m_ovr));
`ifdef SERIAL_RX_ERR_COUNT_EN
            chk("err_count", 64'(err_count), 64'(m_cnt));
`endif
            if (out_valid && out_ready) begin
                acc_cyc.push_back(cyc + 1);
                acc_data.push_back(out_data);
            end
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
        end
    end

    initial begin
        int cs;
        int sel;
        sin       = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b0;
`ifdef SERIAL_RX_ERR_COUNT_EN
        err_clr   = 1'b0;
`endif
        tick(1'b0, 1'b1, 0, '0, 1'b0);
        started = 1'b1;
        tick(1'b1, 1'b1, 0, '0, 1'b0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_pulses", 64'({frame_err, overrun}), 64'd0);
        idle(2);

        // Single frame, latency and one-cycle valid.
        ready_mode = 1;
        clear_mon();
        send_frame(40'hA5_1234_5678, 0, -1, 1'b0, cs);
        idle(2);
        chk("t1_words", 64'(acc_cyc.size()), 64'd1);
        if (acc_cyc.size() >= 1) begin
            chk("t1_latency", 64'(acc_cyc[0] - cs), 64'd42);
            chk("t1_data", 64'(acc_data[0]), 64'hA5_1234_5678);
        end
        chk("t1_errs", 64'(n_ferr + n_ovr), 64'd0);
        chk("t1_valid_low", 64'(out_valid), 64'd0);

        // Back-to-back frames.
        clear_mon();
        send_frame(40'h00_0000_0001, 0, -1, 1'b0, cs);
        send_frame(40'hFF_FFFF_FFFF, 0, -1, 1'b0, cs);
        idle(2);
        chk("t2_words", 64'(acc_cyc.size()), 64'd2);
        if (acc_cyc.size() >= 2) begin
            chk("t2_data0", 64'(acc_data[0]), 64'h00_0000_0001);
            chk("t2_data1", 64'(acc_data[1]), 64'hFF_FFFF_FFFF);
            chk("t2_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd42);
        end

        // Overrun with consumer stalled.
        ready_mode = 0;
        clear_mon();
        send_frame(40'h11_1111_1111, 0, -1, 1'b0, cs);
        send_frame(40'h22_2222_2222, 0, -1, 1'b0, cs);
        idle(1);
        chk("t3_overruns", 64'(n_ovr), 64'd1);
        chk("t3_hold_data", 64'(out_data), 64'h11_1111_1111);
        chk("t3_hold_valid", 64'(out_valid), 64'd1);
        ready_mode = 1;
        idle(3);
        chk("t3_words", 64'(acc_cyc.size()), 64'd1);
        if (acc_cyc.size() >= 1) chk("t3_data", 64'(acc_data[0]), 64'h11_1111_1111);
        chk("t3_valid_low", 64'(out_valid), 64'd0);

        // Framing error with line held high, then recovery.
        clear_mon();
        send_frame(40'h12_3456_789A, 3, -1, 1'b0, cs);
        idle(1);
        chk("t4_ferr", 64'(n_ferr), 64'd1);
        chk("t4_no_word", 64'(acc_cyc.size()), 64'd0);
        send_frame(40'h0F_0F0F_0F0F, 0, -1, 1'b0, cs);
        idle(2);
        chk("t4_words", 64'(acc_cyc.size()), 64'd1);
        if (acc_cyc.size() >= 1) chk("t4_data", 64'(acc_data[0]), 64'h0F_0F0F_0F0F);

        // Reset mid-frame.
        clear_mon();
        send_frame(rand_word(), 0, 20, 1'b0, cs);
        idle(3);
        chk("t5_silent", 64'(acc_cyc.size() + n_ferr + n_ovr), 64'd0);
        send_frame(40'hDE_ADBE_EF01, 0, -1, 1'b0, cs);
        idle(2);
        chk("t5_words", 64'(acc_cyc.size()), 64'd1);
        if (acc_cyc.size() >= 1) chk("t5_data", 64'(acc_data[0]), 64'hDE_ADBE_EF01);

        // Randomized traffic.
        ready_mode = 2;
        for (int f = 0; f < 150; f++) begin
            idle($urandom_range(0, 2));
            sel = $urandom_range(0, 19);
            if (sel < 2)      send_frame(rand_word(), 0, $urandom_range(0, W - 1), 1'b0, cs);
            else if (sel < 5) send_frame(rand_word(), $urandom_range(1, 3), -1, 1'b0, cs);
            else              send_frame(rand_word(), 0, -1, 1'b0, cs);
        end
        ready_mode = 1;
        idle(3);

`ifdef SERIAL_RX_ERR_COUNT_EN
        for (int f = 0; f < 300; f++) send_frame(rand_word(), 1, -1, 1'b0, cs);
        idle(2);
        chk("ec_saturate", 64'(err_count), 64'd255);
        tick(1'b0, 1'b0, 0, '0, 1'b1);
        idle(1);
        chk("ec_clear", 64'(err_count), 64'd0);
        send_frame(rand_word(), 1, -1, 1'b1, cs);
        idle(2);
        chk("ec_clear_wins", 64'(err_count), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
